// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- instruction-fetch initiator for the MIPS core.
//
// Owns the PC, drives the instruction-memory port toward a combinational ROM
// and registers the returned word into the IF/ID pipeline register. It
// handles stalls, taken branches with one delay slot (including branches that
// resolve while the pipeline is stalled) and flush redirects from the
// exception unit. Flush has the highest priority.
//
// Optional feature macro: INST_FETCH_ADDR_ERR_EN
//   defined   : a misaligned PC raises id_adel and parks the block in S_ERR
//               until a flush.
//   undefined : the misaligned PC fetches the aligned word; id_adel stays 0.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               hold PC, IF/ID and FSM state
//   flush, flush_pc     exception/eret redirect (highest priority)
//   branch_en,
//   branch_target       taken branch/jump resolved in ID
//   inst_ce, inst_addr  instruction-memory enable and byte address
//   inst                fetched word, valid in the same cycle as inst_ce
//   id_pc, id_inst,
//   id_valid, id_adel   IF/ID pipeline register
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic        inst_ce,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        id_adel
);

`ifdef INST_FETCH_ADDR_ERR_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ERR   = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        id_adel_q, id_adel_d;
  logic [31:0] pc_next_s;

  // Memory port driven straight from the PC/state registers.
`ifdef INST_FETCH_ADDR_ERR_EN
  assign inst_addr = pc_q;
  assign inst_ce   = (state_q == S_FETCH) && (pc_q[1:0] == 2'b00);
`else
  assign inst_addr = {pc_q[31:2], 2'b00};
  assign inst_ce   = (state_q == S_FETCH);
`endif

  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;
  assign id_adel  = id_adel_q;

  // Sequential PC on an unstalled advance: a branch caught during a stall
  // (br_pend) takes precedence over one arriving on the release cycle.
  always_comb begin
    if (br_pend_q) begin
      pc_next_s = br_tgt_q;
    end else if (branch_en) begin
      pc_next_s = branch_target;
    end else begin
      pc_next_s = pc_q + 32'd4;
    end
  end

  // Next-state logic for the FSM, PC, pending branch and IF/ID register.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    br_pend_d  = br_pend_q;
    br_tgt_d   = br_tgt_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    id_adel_d  = id_adel_q;

    if (flush) begin
      pc_d       = flush_pc;
      br_pend_d  = 1'b0;
      id_pc_d    = 32'd0;
      id_inst_d  = 32'd0;
      id_valid_d = 1'b0;
      id_adel_d  = 1'b0;
      state_d    = S_FETCH;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FETCH;
        end
        S_FETCH: begin
          if (stall) begin
            // Remember a branch resolved while frozen; the latest one wins.
            if (branch_en) begin
              br_pend_d = 1'b1;
              br_tgt_d  = branch_target;
            end else begin
              br_pend_d = br_pend_q;
            end
          end
`ifdef INST_FETCH_ADDR_ERR_EN
          else if (pc_q[1:0] != 2'b00) begin
            id_pc_d    = pc_q;
            id_inst_d  = 32'd0;
            id_valid_d = 1'b1;
            id_adel_d  = 1'b1;
            br_pend_d  = 1'b0;
            state_d    = S_ERR;
          end
`endif
          else begin
            id_pc_d    = pc_q;
            id_inst_d  = inst;
            id_valid_d = 1'b1;
            id_adel_d  = 1'b0;
            pc_d       = pc_next_s;
            br_pend_d  = 1'b0;
          end
        end
`ifdef INST_FETCH_ADDR_ERR_EN
        S_ERR: begin
          // Parked: only a flush leaves; branches are ignored.
          id_valid_d = 1'b0;
        end
`endif
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      br_pend_q  <= 1'b0;
      br_tgt_q   <= 32'd0;
      id_pc_q    <= 32'd0;
      id_inst_q  <= 32'd0;
      id_valid_q <= 1'b0;
      id_adel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      br_pend_q  <= br_pend_d;
      br_tgt_q   <= br_tgt_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      id_adel_q  <= id_adel_d;
    end
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch initiator for the MIPS core. It owns the PC and drives the instruction-memory port (`inst_ce`, `inst_addr`) toward the combinational instruction ROM. It registers the returned word into the IF/ID pipeline register. It handles stall, branch redirect with one delay slot, and flush redirect from the exception unit.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: first fetch address after reset.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: freeze PC and IF/ID (pipeline hazard).
- `flush` in 1: exception/eret redirect; highest priority.
- `flush_pc` in 32: redirect target when `flush`=1.
- `branch_en` in 1: taken branch/jump resolved in ID.
- `branch_target` in 32: target when `branch_en`=1.
- `inst_ce` out 1: instruction-memory enable.
- `inst_addr` out 32: fetch byte address (current PC).
- `inst` in 32: fetched word, valid in the same cycle `inst_ce`=1; memory delivers it already byte-ordered.
- `id_pc` out 32: IF/ID registered PC.
- `id_inst` out 32: IF/ID registered instruction.
- `id_valid` out 1: IF/ID holds a real instruction.
- `id_adel` out 1: fetch address error flag (see Configuration).

## Operation
- State: `pc` (32), `br_pend` (1), `br_tgt` (32), FSM {S_IDLE, S_FETCH, S_ERR}.
- Outputs: `inst_addr`=`pc`; `inst_ce`=1 only in S_FETCH with an aligned `pc`.
- S_IDLE: entered on reset. `inst_ce`=0. It moves to S_FETCH on the next clock unconditionally, unless `flush`, which loads `pc`<=`flush_pc` and still goes to S_FETCH.
- S_FETCH advance (no stall, no flush):
  - IF/ID <= {`pc`, `inst`, valid=1}.
  - `pc` <= `br_pend` ? `br_tgt` : `branch_en` ? `branch_target` : `pc`+4, with 32-bit wrap.
  - `br_pend` cleared.
- Branch delay slot: when `branch_en` arrives, the word being fetched that cycle is the delay slot. It is captured into IF/ID normally, and the target is fetched next.
- Stall (no flush):
  - `pc`, IF/ID, and FSM state hold.
  - `inst_ce` stays as is, re-reading the same address.
  - If `branch_en`=1: `br_pend`<=1, `br_tgt`<=`branch_target`. A later `branch_en` during the same stall overwrites `br_tgt`.
- Flush (any state, overrides stall and branch):
  - `pc`<=`flush_pc`; `br_pend`<=0.
  - IF/ID <= {0, 0, valid=0}; `id_adel`<=0.
  - State -> S_FETCH.
- `id_inst` is passed through unchanged from `inst`; the fetch unit does no byte swapping.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `inst_addr`=`RESET_PC`, `inst_ce`=0.
  - `id_pc`=0, `id_inst`=0, `id_valid`=0, `id_adel`=0.
  - `br_pend`=0, state S_IDLE.
- Reset is asynchronous on `rst_n` fall; mid-operation it discards any pending branch and any IF/ID content immediately.
- Cycle 0 after reset release: S_IDLE, `inst_ce`=0. Cycle 1: `inst_addr`=`RESET_PC`, `inst_ce`=1. Cycle 2: `id_pc`=`RESET_PC`, `id_valid`=1.
- Fetch-to-IF/ID latency is 1 cycle; throughput is 1 word/cycle when unstalled.
- Redirect latency:
  - `branch_en` or `flush` at edge N puts the new address on `inst_addr` in cycle N+1.
  - After a flush, the first valid IF/ID entry appears at N+2.
- Simultaneous `flush` and `stall`: the flush wins, and the stall is ignored that cycle.
- Simultaneous `br_pend` and new `branch_en` on the release cycle: `br_tgt` wins.

## Configuration
- Macro: `INST_FETCH_ADDR_ERR_EN`.
- Defined: a fetch with `pc[1:0]`≠0 in S_FETCH behaves as follows.
  - `inst_ce`=0.
  - On the next unstalled edge, IF/ID <= {`pc`, 0, valid=1} and `id_adel`<=1.
  - State -> S_ERR.
  - S_ERR holds `inst_ce`=0 and `id_valid`=0 on subsequent cycles, ignores `branch_en`, and leaves only on `flush`.
- Not defined:
  - `inst_addr`={`pc[31:2]`, 2'b00}.
  - `id_adel` is tied 0.
  - S_ERR does not exist; a misaligned PC fetches the aligned word.

## Test plan
- Reset then run with a ROM of 4 words: `inst_addr` sequence BFC00000, 04, 08, 0C. `id_valid` first rises 2 cycles after release, and `id_pc` lags `inst_addr` by 1 cycle.
- `branch_en`=1, target 0xBFC00100, while fetching 0xBFC00008: `id_pc` shows 0xBFC00008 (delay slot), then 0xBFC00100, 0xBFC00104.
- `stall`=1 for 3 cycles with `branch_en` pulsed in the 2nd stall cycle (target 0xBFC00200):
  - `inst_addr`/IF/ID frozen during the stall.
  - After release, the frozen word is captured, then 0xBFC00200 is fetched.
- `flush`=1 with `stall`=1 and `flush_pc`=0xBFC00380: next cycle `inst_addr`=0xBFC00380 and `id_valid`=0; the pending branch is discarded.
- With `INST_FETCH_ADDR_ERR_EN`, `flush_pc`=0xBFC00382:
  - `inst_ce`=0; next cycle `id_adel`=1, `id_pc`=0xBFC00382, `id_inst`=0.
  - The block then idles until a `flush` to 0xBFC00380 resumes fetching.
- Assert `rst_n`=0 mid-stream: outputs reach their reset values without a clock edge, and fetch restarts at `RESET_PC`.
